// File: rtl/spi_flash_pkg.sv
// Shared encodings for the flash read arbiter: FSM states, port select and the error fill word.
package spi_flash_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef logic port_sel_t;

    localparam port_sel_t PORT_IF = 1'b0;
    localparam port_sel_t PORT_D  = 1'b1;

    localparam int                    ERR_WORD_W = 16;
    localparam logic [ERR_WORD_W-1:0] ERR_WORD   = '1;

endpackage

// File: rtl/fetch_line_buffer.sv
// One-entry fetch buffer: full-width address compare, load from the engine, flush.
// Flush has priority over a same-cycle load so a flushed line can never come back valid.
module fetch_line_buffer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            addr_d  = load_addr_i;
            data_d  = load_data_i;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign hit_o  = valid_q && (addr_q == lookup_addr_i);
    assign data_o = data_q;

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one SPI flash read engine between instruction fetch and data load, with a
// one-entry fetch buffer, bounded data streaks while a fetch miss waits, and a read timeout.
module flash_read_arbiter
    import spi_flash_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_err_o,
    input  logic              d_req_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_err_o,
    input  logic              flush_i,
    output logic              eng_start_o,
    output logic [ADDR_W-1:0] eng_addr_o,
    input  logic              eng_busy_i,
    input  logic              eng_done_i,
    input  logic [DATA_W-1:0] eng_data_i
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam int CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [DATA_W-1:0]   ERR_FILL   = {DATA_W{ERR_WORD[0]}};
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    port_sel_t           winner_q, winner_d;
    logic [ADDR_W-1:0]   eng_addr_q, eng_addr_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [CNT_W-1:0]    tmo_q, tmo_d;
    logic                if_ack_q, if_ack_d, if_err_q, if_err_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic              buf_hit;
    logic [DATA_W-1:0] buf_data;
    logic              buf_load;
    logic              fetch_owned;
    logic              fetch_hit, fetch_miss, data_pend;
    logic              arb_open, grant;
    port_sel_t         grant_port;
    logic              done_ok, timed_out, complete;

    fetch_line_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fetch_buf (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .load_i        (buf_load),
        .load_addr_i   (eng_addr_q),
        .load_data_i   (eng_data_i),
        .lookup_addr_i (if_addr_i),
        .hit_o         (buf_hit),
        .data_o        (buf_data)
    );

    // A port whose ack is high is not sampled; the requester re-presents next cycle.
    assign fetch_owned = (state_q != ST_IDLE) && (winner_q == PORT_IF);
    assign fetch_hit   = if_req_i && !if_ack_q && buf_hit && !fetch_owned;
    assign fetch_miss  = if_req_i && !if_ack_q && !buf_hit && !fetch_owned;
    assign data_pend   = d_req_i && !d_ack_q;

    // Arbitrate only once the previous ack has landed, so a requester that keeps its
    // request up across the ack is seen as a competitor for the next grant.
    assign arb_open   = (state_q == ST_IDLE) && !eng_busy_i && !if_ack_q && !d_ack_q;
    assign grant      = arb_open && (fetch_miss || data_pend);
    assign grant_port = (data_pend && !(fetch_miss && (streak_q == STREAK_MAX))) ? PORT_D : PORT_IF;

    assign done_ok   = (state_q == ST_WAIT) && eng_done_i;
    assign timed_out = (state_q == ST_WAIT) && !eng_done_i && (tmo_q == CNT_LAST);
    assign complete  = done_ok || timed_out;
    assign buf_load  = done_ok && (winner_q == PORT_IF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (grant) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (complete) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        eng_start_o = (state_q == ST_ISSUE);
    end

    always_comb begin
        winner_d   = winner_q;
        eng_addr_d = eng_addr_q;
        if (grant) begin
            winner_d   = grant_port;
            eng_addr_d = (grant_port == PORT_D) ? d_addr_i : if_addr_i;
        end

        tmo_d = '0;
        if ((state_q == ST_WAIT) && !complete) begin
            tmo_d = tmo_q + CNT_W'(1);
        end

        // Streak only counts data grants made while a fetch miss is waiting.
        streak_d = streak_q;
        if (grant && (grant_port == PORT_D) && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
        end
        if ((grant && (grant_port == PORT_IF)) || fetch_hit ||
            ((state_q == ST_IDLE) && !fetch_miss)) begin
            streak_d = '0;
        end

        if_ack_d   = 1'b0;
        if_err_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        d_ack_d    = 1'b0;
        d_err_d    = 1'b0;
        d_rdata_d  = d_rdata_q;
        if (fetch_hit) begin
            if_ack_d   = 1'b1;
            if_rdata_d = buf_data;
        end
        if (complete) begin
            if (winner_q == PORT_IF) begin
                if_ack_d   = 1'b1;
                if_err_d   = timed_out;
                if_rdata_d = timed_out ? ERR_FILL : eng_data_i;
            end else begin
                d_ack_d   = 1'b1;
                d_err_d   = timed_out;
                d_rdata_d = timed_out ? ERR_FILL : eng_data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner_q   <= PORT_IF;
            eng_addr_q <= '0;
            streak_q   <= '0;
            tmo_q      <= '0;
            if_ack_q   <= 1'b0;
            if_err_q   <= 1'b0;
            if_rdata_q <= '0;
            d_ack_q    <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            winner_q   <= winner_d;
            eng_addr_q <= eng_addr_d;
            streak_q   <= streak_d;
            tmo_q      <= tmo_d;
            if_ack_q   <= if_ack_d;
            if_err_q   <= if_err_d;
            if_rdata_q <= if_rdata_d;
            d_ack_q    <= d_ack_d;
            d_err_q    <= d_err_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign if_ack_o   = if_ack_q;
    assign if_err_o   = if_err_q;
    assign if_rdata_o = if_rdata_q;
    assign d_ack_o    = d_ack_q;
    assign d_err_o    = d_err_q;
    assign d_rdata_o  = d_rdata_q;
    assign eng_addr_o = eng_addr_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Bench for flash_read_arbiter: a stub SPI engine, a cycle model of the sharing rules, and directed scenarios.
module tb_flash_read_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int MAXS = 4;
    localparam int TMO  = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0, d_req = 1'b0, flush = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic          if_ack_o, if_err_o, d_ack_o, d_err_o, eng_start_o;
    logic [DW-1:0] if_rdata_o, d_rdata_o;
    logic [AW-1:0] eng_addr_o;
    logic          eng_busy = 1'b0, eng_done = 1'b0;
    logic [DW-1:0] eng_data = '0;

    always #5 clk = ~clk;

    flash_read_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .d_req_i(d_req), .d_addr_i(d_addr), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
        .flush_i(flush), .eng_start_o(eng_start_o), .eng_addr_o(eng_addr_o),
        .eng_busy_i(eng_busy), .eng_done_i(eng_done), .eng_data_i(eng_data)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] flash_word(input logic [15:0] a);
        case (a)
            16'h1234: flash_word = 16'hABCD;
            16'h1235: flash_word = 16'h5566;
            16'h9000: flash_word = 16'hDEAD;
            default:  flash_word = a ^ 16'hC3C3;
        endcase
    endfunction

    // Stub engine: busy from start for eng_lat cycles, then a done pulse with the flash word.
    int          eng_lat = 3;
    bit          flush_now = 0;
    bit          flush_with_done = 0;
    logic [15:0] cap_addr = '0;
    int          left = 0;

    always begin
        @(posedge clk);
        #1;
        eng_done = 1'b0;
        if (rst) begin
            eng_busy = 1'b0;
            left     = 0;
        end else if (eng_busy) begin
            left--;
            if (left <= 0) begin
                eng_busy = 1'b0;
                eng_done = 1'b1;
                eng_data = flash_word(cap_addr);
            end
        end else if (eng_start_o) begin
            eng_busy = 1'b1;
            cap_addr = eng_addr_o;
            left     = eng_lat;
        end
        #1;
        flush = flush_now | (flush_with_done & eng_done);
    end

    logic [15:0] start_q[$];
    always @(negedge clk) begin
        if (!rst && eng_start_o) start_q.push_back(eng_addr_o);
    end

    // Reference model: what each output must be next cycle, from the sharing rules.
    logic        m_bv;
    logic [15:0] m_ba, m_bd, m_eaddr, m_if_rdata, m_d_rdata;
    int          m_phase, m_cnt, m_streak;   // phase: 0 free, 1 launch due, 2 engine reading
    bit          m_own_d;
    logic        m_if_ack, m_if_err, m_d_ack, m_d_err;

    always @(negedge clk) begin : model
        bit f_own, match, hit, miss, dp, gnt, take_d;
        logic        n_bv, n_if_ack, n_if_err, n_d_ack, n_d_err;
        logic [15:0] n_ba, n_bd, n_eaddr, n_if_rdata, n_d_rdata;
        int          n_phase, n_cnt, n_streak;
        bit          n_own_d;
        if (rst) begin
            m_bv = 0; m_ba = '0; m_bd = '0; m_eaddr = '0; m_if_rdata = '0; m_d_rdata = '0;
            m_phase = 0; m_cnt = 0; m_streak = 0; m_own_d = 0;
            m_if_ack = 0; m_if_err = 0; m_d_ack = 0; m_d_err = 0;
        end
        check("if_ack", if_ack_o, m_if_ack);
        check("if_err", if_err_o, m_if_err);
        check("if_rdata", if_rdata_o, m_if_rdata);
        check("d_ack", d_ack_o, m_d_ack);
        check("d_err", d_err_o, m_d_err);
        check("d_rdata", d_rdata_o, m_d_rdata);
        check("eng_start", eng_start_o, (m_phase == 1));
        check("eng_addr", eng_addr_o, m_eaddr);
        if (!rst) begin
            f_own  = (m_phase != 0) && !m_own_d;
            match  = m_bv && (if_addr == m_ba);
            hit    = if_req && !m_if_ack && match && !f_own;
            miss   = if_req && !m_if_ack && !match && !f_own;
            dp     = d_req && !m_d_ack;
            gnt    = (m_phase == 0) && !eng_busy && !m_if_ack && !m_d_ack && (miss || dp);
            take_d = dp && !(miss && (m_streak == MAXS));
            n_bv = m_bv; n_ba = m_ba; n_bd = m_bd; n_eaddr = m_eaddr;
            n_phase = m_phase; n_cnt = m_cnt; n_own_d = m_own_d;
            n_if_ack = 0; n_if_err = 0; n_if_rdata = m_if_rdata;
            n_d_ack = 0; n_d_err = 0; n_d_rdata = m_d_rdata;
            if (hit) begin n_if_ack = 1; n_if_rdata = m_bd; end
            n_streak = m_streak;
            if (gnt && take_d) n_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
            if ((gnt && !take_d) || hit || ((m_phase == 0) && !miss)) n_streak = 0;
            if (m_phase == 0) begin
                if (gnt) begin
                    n_own_d = take_d;
                    n_eaddr = take_d ? d_addr : if_addr;
                    n_phase = 1;
                end
            end else if (m_phase == 1) begin
                n_phase = 2;
                n_cnt   = 0;
            end else begin
                if (eng_done || (m_cnt == TMO - 1)) begin
                    n_phase = 0;
                    n_cnt   = 0;
                    if (m_own_d) begin
                        n_d_ack = 1; n_d_err = !eng_done; n_d_rdata = eng_done ? eng_data : 16'hFFFF;
                    end else begin
                        n_if_ack = 1; n_if_err = !eng_done; n_if_rdata = eng_done ? eng_data : 16'hFFFF;
                        if (eng_done) begin n_bv = 1; n_ba = m_eaddr; n_bd = eng_data; end
                    end
                end else begin
                    n_cnt = m_cnt + 1;
                end
            end
            if (flush) n_bv = 0;
            m_bv = n_bv; m_ba = n_ba; m_bd = n_bd; m_eaddr = n_eaddr;
            m_phase = n_phase; m_cnt = n_cnt; m_own_d = n_own_d; m_streak = n_streak;
            m_if_ack = n_if_ack; m_if_err = n_if_err; m_if_rdata = n_if_rdata;
            m_d_ack = n_d_ack; m_d_err = n_d_err; m_d_rdata = n_d_rdata;
        end
    end

    // Raise a request, wait (bounded) for its ack, keep it through the ack cycle, then drop it.
    task automatic do_req(input bit is_d, input logic [15:0] a, output logic [15:0] data,
                          output logic err, output int lat);
        bit got;
        got = 0; lat = 0; data = '0; err = 0;
        if (is_d) begin d_req = 1; d_addr = a; end
        else      begin if_req = 1; if_addr = a; end
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (is_d ? d_ack_o : if_ack_o) begin
                got  = 1;
                data = is_d ? d_rdata_o : if_rdata_o;
                err  = is_d ? d_err_o : if_err_o;
            end
        end
        check("ack_within_budget", got, 1'b1);
        @(posedge clk); #1;
        if (is_d) d_req = 0; else if_req = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [15:0] data;
        logic        err;
        int          lat, base, dacks;
        bit          got;

        #1 rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_if_ack", if_ack_o, 0);
        check("rst_d_ack", d_ack_o, 0);
        check("rst_eng_start", eng_start_o, 0);
        check("rst_eng_addr", eng_addr_o, 16'h0000);
        check("rst_if_rdata", if_rdata_o, 16'h0000);
        check("rst_d_rdata", d_rdata_o, 16'h0000);
        @(posedge clk); #1 rst = 0;
        repeat (2) @(posedge clk); #1;

        // 1: first fetch misses and goes to the engine
        base = start_q.size();
        do_req(0, 16'h1234, data, err, lat);
        check("t1_rdata", data, 16'hABCD);
        check("t1_err", err, 0);
        check("t1_latency", lat, 5);
        check("t1_starts", start_q.size() - base, 1);
        if (start_q.size() > base) check("t1_start_addr", start_q[base], 16'h1234);

        // 2: repeat hits the buffer, neighbour misses
        base = start_q.size();
        do_req(0, 16'h1234, data, err, lat);
        check("t2_hit_rdata", data, 16'hABCD);
        check("t2_hit_latency", lat, 1);
        check("t2_hit_no_start", start_q.size() - base, 0);
        do_req(0, 16'h1235, data, err, lat);
        check("t2_miss_rdata", data, 16'h5566);
        check("t2_miss_latency", lat, 5);
        check("t2_miss_starts", start_q.size() - base, 1);

        // 3: continuous data load versus a waiting fetch miss
        base = start_q.size();
        dacks = 0; got = 0;
        d_req = 1; d_addr = 16'h9000; if_req = 1; if_addr = 16'h2000;
        for (int i = 0; i < 500 && !got; i++) begin
            @(posedge clk); #1;
            if (d_ack_o) begin dacks++; check("t3_d_rdata", d_rdata_o, 16'hDEAD); end
            if (if_ack_o) begin got = 1; check("t3_if_rdata", if_rdata_o, 16'hE3C3); end
        end
        check("t3_fetch_served", got, 1'b1);
        check("t3_data_acks_before_fetch", dacks, MAXS);
        @(posedge clk); #1 if_req = 0;
        got = 0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(posedge clk); #1;
            if (d_ack_o) got = 1;
        end
        check("t3_tail_data_served", got, 1'b1);
        @(posedge clk); #1 d_req = 0;
        check("t3_starts_enough", (start_q.size() - base) >= 5, 1'b1);
        if (start_q.size() - base >= 5) begin
            for (int k = 0; k < 4; k++) check("t3_data_grant", start_q[base + k], 16'h9000);
            check("t3_fetch_grant", start_q[base + 4], 16'h2000);
        end
        repeat (3) @(posedge clk); #1;

        // 4: engine silent past the timeout; late done and lingering busy follow
        eng_lat = 1100;
        do_req(1, 16'h0100, data, err, lat);
        eng_lat = 3;
        check("t4_err", err, 1);
        check("t4_rdata", data, 16'hFFFF);
        check("t4_latency", lat, TMO + 2);
        do_req(0, 16'h5000, data, err, lat);
        check("t4_after_busy_rdata", data, 16'h93C3);
        check("t4_after_busy_latency", lat, 79);
        repeat (2) @(posedge clk); #1;

        // 5: flush behaviour
        do_req(0, 16'h1234, data, err, lat);
        do_req(0, 16'h1234, data, err, lat);
        check("t5_hit_before_flush", lat, 1);
        flush_now = 1;
        @(posedge clk); #1 flush_now = 0;
        base = start_q.size();
        do_req(0, 16'h1234, data, err, lat);
        check("t5_miss_after_flush", lat, 5);
        check("t5_start_after_flush", start_q.size() - base, 1);
        flush_with_done = 1;
        do_req(0, 16'h1235, data, err, lat);
        flush_with_done = 0;
        check("t5_coincident_rdata", data, 16'h5566);
        do_req(0, 16'h1235, data, err, lat);
        check("t5_coincident_left_invalid", lat, 5);
        flush_now = 1;
        do_req(0, 16'h1235, data, err, lat);
        flush_now = 0;
        check("t5_hit_in_flush_cycle", lat, 1);
        check("t5_hit_in_flush_rdata", data, 16'h5566);
        do_req(0, 16'h1235, data, err, lat);
        check("t5_miss_after_hit_flush", lat, 5);

        // 6: asynchronous reset in the middle of an engine read
        do_req(0, 16'h3000, data, err, lat);
        do_req(0, 16'h3000, data, err, lat);
        check("t6_hit_before_reset", lat, 1);
        eng_lat = 8;
        if_req = 1; if_addr = 16'h4000;
        repeat (4) @(posedge clk);
        #3 rst = 1; if_req = 0;
        #1;
        check("t6_async_eng_start", eng_start_o, 0);
        check("t6_async_eng_addr", eng_addr_o, 16'h0000);
        check("t6_async_if_rdata", if_rdata_o, 16'h0000);
        check("t6_async_acks", {if_ack_o, d_ack_o, if_err_o, d_err_o}, 4'b0000);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        eng_lat = 3;
        repeat (2) @(posedge clk); #1;
        base = start_q.size();
        do_req(0, 16'h3000, data, err, lat);
        check("t6_buffer_cleared", lat, 5);
        check("t6_fresh_rdata", data, 16'hF3C3);
        check("t6_fresh_start", start_q.size() - base, 1);

        repeat (3) @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
Shares the single-SPI flash read engine between the CPU instruction-fetch port and the data-load port. It owns a one-entry fetch buffer, so a repeated fetch address is answered without touching SPI. It also sequences engine start/done and enforces a read timeout. It sits between the CPU and the SPI read engine, and the engine's address/instruction/ready interface moves behind this block.

Parameters:
ADDR_W, 16, request/engine address width
DATA_W, 16, read word width
MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch miss is pending
TIMEOUT_CYCLES, 1024, WAIT cycles before a read is aborted with error

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held with stable if_addr until if_ack
if_addr  in  ADDR_W  fetch word address
if_ack  out  1  one-cycle fetch completion pulse (registered)
if_rdata  out  DATA_W  fetch data; valid with if_ack, held until next if_ack
if_err  out  1  qualifies if_ack; 1 = timeout
d_req  in  1  data-load request; same protocol as if_req
d_addr  in  ADDR_W  data word address
d_ack  out  1  one-cycle data completion pulse (registered)
d_rdata  out  DATA_W  data read result; held until next d_ack
d_err  out  1  qualifies d_ack; 1 = timeout
flush  in  1  invalidate fetch buffer
eng_start  out  1  one-cycle pulse launching an engine read
eng_addr  out  ADDR_W  engine address; stable from eng_start until eng_done
eng_busy  in  1  engine transaction in progress
eng_done  in  1  one-cycle pulse, eng_data valid
eng_data  in  DATA_W  word read from flash

Behaviour:
- Reset (async): state=IDLE. All acks, errs, eng_start = 0. if_rdata, d_rdata, eng_addr = 0. Buffer invalid, streak=0, timeout counter=0.
- Requester rule: a port whose ack is high this cycle is not sampled. The requester drops req, or presents a new address, the cycle after ack.
- Hit path, any state: if_req & buf_valid & if_addr==buf_addr & fetch not granted & !if_ack -> if_ack=1, if_rdata=buf_data, if_err=0 next cycle. Latency is 1 cycle and runs concurrently with an engine read for the data port.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: candidates are d_req and a fetch miss, both only when eng_busy=0.
    - Both pending: grant data unless streak==MAX_DATA_STREAK, in which case grant fetch.
    - Latch winner and address into eng_addr, go ISSUE.
  - ISSUE: eng_start=1 for exactly one cycle, go WAIT.
  - WAIT: timeout counter increments each cycle.
    - On eng_done: winner's rdata<=eng_data, ack pulse next cycle, err=0, counter cleared, go IDLE.
    - If the winner is fetch: buf_addr<=eng_addr, buf_data<=eng_data, buf_valid<=1.
    - If counter reaches TIMEOUT_CYCLES-1 without eng_done: ack with err=1, rdata=ERR_WORD (all ones), buffer not updated, go IDLE.
- Streak counter:
  - +1 on each data grant, saturating at MAX_DATA_STREAK.
  - Cleared on fetch grant, on a fetch hit, or on an IDLE cycle with no fetch miss pending.
- Worst-case turnaround: ack one cycle after eng_done, so the next grant can issue 2 cycles after eng_done.
- flush: buf_valid<=0 next cycle. flush in the same cycle as a fetch eng_done leaves the buffer invalid (flush wins). A hit in the flush cycle is still served.
- A late eng_done after a timeout is ignored in IDLE, but eng_busy still blocks new grants until it drops.
- Address equality is full ADDR_W compare; there is no wrap-around or partial tag.

Decomposition:
- Shared package spi_flash_pkg holds:
  - FSM state encoding, 2-bit: IDLE=0, ISSUE=1, WAIT=2.
  - Port-select constant: PORT_IF=0, PORT_D=1.
  - ERR_WORD.
- Natural sub-module: fetch_line_buffer, holding valid/addr/data registers with hit compare, load, and flush.
- Arbitration and the FSM stay in the top module.

Test Plan:
1. Reset, then if_req addr 0x1234, engine returns 0xABCD -> one eng_start with eng_addr=0x1234; if_ack one cycle after eng_done; if_rdata=0xABCD, if_err=0.
2. Re-request 0x1234 -> if_ack on the next cycle, no eng_start, if_rdata=0xABCD. Then request 0x1235 (0x5566) -> a miss, engine used.
3. d_req 0x9000 held continuously (returns 0xDEAD) with fetch miss 0x2000 pending -> exactly 4 data grants, then a fetch grant; no starvation.
4. Engine never asserts eng_done for d_req 0x0100 -> d_ack with d_err=1 and d_rdata=0xFFFF after TIMEOUT_CYCLES; FSM back in IDLE.
5. Assert flush after buffering 0x1234, then request 0x1234 -> miss, new eng_start. Also assert flush coincident with a fetch eng_done -> buffer stays invalid.
6. Assert rst during WAIT -> all outputs 0 immediately (async), buffer invalid. A fresh request after release completes normally.
